// File: rtl/shift_arbiter.sv
// Shared iterative shift engine for NUM_REQ requesters.
// A round-robin arbiter picks one request at a time. The operand is then
// shifted one bit per cycle. The result is returned on a single response
// channel, tagged with the index of the requester that owns it.
module shift_arbiter #(
  parameter  int DATA_W  = 8,
  parameter  int NUM_REQ = 2,
  localparam int SHAMT_W = $clog2(DATA_W),
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  input  logic [NUM_REQ*SHAMT_W-1:0] req_shamt_i,
  input  logic [NUM_REQ*2-1:0]       req_op_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [DATA_W-1:0]          rsp_data_o,
  output logic [ID_W-1:0]            rsp_id_o,
  output logic                       busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    acc_q;
  logic [SHAMT_W-1:0]   cnt_q;
  logic [1:0]           op_q;
  logic [ID_W-1:0]      id_q;
  logic [ID_W-1:0]      rr_q;

  logic                 any_valid;
  logic [ID_W-1:0]      grant_id;
  logic [ID_W-1:0]      rr_next;
  logic [DATA_W-1:0]    step;

  // Per-requester views of the flattened request buses.
  logic [DATA_W-1:0]    data_arr  [NUM_REQ];
  logic [SHAMT_W-1:0]   shamt_arr [NUM_REQ];
  logic [1:0]           op_arr    [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi]  = req_data_i[gi*DATA_W +: DATA_W];
    assign shamt_arr[gi] = req_shamt_i[gi*SHAMT_W +: SHAMT_W];
    assign op_arr[gi]    = req_op_i[gi*2 +: 2];
  end

  // Round-robin search: the first valid requester at or above rr_q, wrapping.
  // The loop runs downward so that the closest candidate is written last and wins.
  always_comb begin : p_grant
    logic [ID_W:0] sum;
    any_valid = 1'b0;
    grant_id  = '0;
    sum       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      if (req_valid_i[sum[ID_W-1:0]]) begin
        any_valid = 1'b1;
        grant_id  = sum[ID_W-1:0];
      end
    end
  end

  // Pointer after a grant: the requester just above the winner, wrapping.
  always_comb begin
    rr_next = grant_id + 1'b1;
    if (grant_id == ID_W'(NUM_REQ - 1)) begin
      rr_next = '0;
    end
  end

  // One-bit step of the latched operation.
  always_comb begin
    case (op_q)
      OP_SLL:  step = {acc_q[DATA_W-2:0], 1'b0};
      OP_SRL:  step = {1'b0, acc_q[DATA_W-1:1]};
      OP_SRA:  step = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
      default: step = {acc_q[DATA_W-2:0], acc_q[DATA_W-1]};
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A zero shift amount goes straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = (shamt_arr[grant_id] == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture the granted request, then step it once per BUSY cycle.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      op_q  <= '0;
      id_q  <= '0;
      rr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            acc_q <= data_arr[grant_id];
            cnt_q <= shamt_arr[grant_id];
            op_q  <= op_arr[grant_id];
            id_q  <= grant_id;
            rr_q  <= rr_next;
          end
        end
        BUSY: begin
          acc_q <= step;
          cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs: ready only in IDLE for the winner; response fields are zero
  // unless a result is being presented, so reset clears them at once.
  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && any_valid && !arst_i) begin
      req_ready_o[grant_id] = 1'b1;
    end
    rsp_valid_o = (state_q == DONE);
    rsp_data_o  = (state_q == DONE) ? acc_q : '0;
    rsp_id_o    = (state_q == DONE) ? id_q : '0;
    busy_o      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter (DATA_W = 8, NUM_REQ = 2).
// The expected response is queued when a request is accepted. A negedge
// monitor checks the grant, busy and response signals against a reference
// model built from the shift and round-robin rules.
module tb_shift_arbiter;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int SW = 3;
  localparam int IW = 1;

  logic            clk = 1'b0;
  logic            arst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_data;
  logic [N*SW-1:0] req_shamt;
  logic [N*2-1:0]  req_op;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_data;
  logic [IW-1:0]   rsp_id;
  logic            busy;

  shift_arbiter #(.DATA_W(W), .NUM_REQ(N)) dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .req_shamt_i (req_shamt),
    .req_op_i    (req_op),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  bit   mbusy    = 1'b0;
  int   mrr      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference shift: whole-word arithmetic instead of bit-by-bit stepping.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [SW-1:0] s,
                                             input logic [1:0] op);
    logic [2*W-1:0] t;
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return W'($signed(d) >>> s);
      default: begin
        t = {d, d} << s;
        return t[2*W-1:W];
      end
    endcase
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin : mon
    logic [N-1:0] exp_rdy;
    int           w;
    int           idx;
    bit           was_busy;
    bit           exp_v;
    exp_t         e;
    cyc++;
    if (arst) begin
      sb.delete();
      mbusy = 1'b0;
      mrr   = 0;
    end else begin
      was_busy = mbusy;
      exp_rdy  = '0;
      w        = -1;
      if (!was_busy) begin
        for (int k = N - 1; k >= 0; k--) begin
          idx = (mrr + k) % N;
          if (req_valid[IW'(idx)]) w = idx;
        end
      end
      if (w >= 0) exp_rdy[IW'(w)] = 1'b1;
      chk("ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(was_busy));
      exp_v = was_busy && (sb.size() > 0) && (cyc >= sb[0].due);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v) begin
        chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
        chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
        if (rsp_ready) begin
          $display("rsp id=%0d data=%02h cycle=%0d", rsp_id, rsp_data, cyc);
          void'(sb.pop_front());
          mbusy = 1'b0;
        end
      end
      if (w >= 0) begin
        e.id   = w;
        e.data = ref_shift(req_data[w*W +: W], req_shamt[w*SW +: SW], req_op[w*2 +: 2]);
        e.due  = cyc + int'(req_shamt[w*SW +: SW]) + 1;
        sb.push_back(e);
        mbusy = 1'b1;
        mrr   = (w + 1) % N;
      end
    end
  end

  task automatic set_req(input int i, input logic [W-1:0] d, input logic [SW-1:0] s,
                         input logic [1:0] op);
    req_data[i*W +: W]    = d;
    req_shamt[i*SW +: SW] = s;
    req_op[i*2 +: 2]      = op;
  endtask

  task automatic wait_grant(input int i);
    bit got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        got = 1'b1;
        break;
      end
    end
    chk("grant_seen", 32'(got), 32'd1);
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("drain_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // One request with a known answer. Inputs are scrambled right after accept.
  task automatic do_op(input string name, input int i, input logic [W-1:0] d,
                       input logic [SW-1:0] s, input logic [1:0] op, input logic [W-1:0] exp);
    int k = 0;
    rsp_ready = 1'b1;
    set_req(i, d, s, op);
    req_valid[i] = 1'b1;
    wait_grant(i);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    set_req(i, ~d, s, ~op);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        k = c;
        break;
      end
    end
    chk({name, "_latency"}, 32'(k), 32'(s) + 32'd1);
    chk({name, "_data"}, 32'(rsp_data), 32'(exp));
    chk({name, "_id"}, 32'(rsp_id), 32'(i));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({name, "_pulse"}, 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int           g;
    int           r;
    int           k;
    int           acc_cnt;
    logic [N-1:0] acc;

    // Reset with both requesters already valid: nothing may be granted.
    arst      = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_shamt = '0;
    req_op    = '0;
    set_req(0, 8'h11, 3'd1, 2'b00);
    set_req(1, 8'h22, 3'd1, 2'b01);
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    arst = 1'b0;

    // Contention: both continuously valid, grants must alternate 0,1,0,1.
    g = 0;
    r = 0;
    for (int c = 0; c < 60 && g < 4; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk("contention_grant", 32'(req_ready), (g % 2 == 0) ? 32'd1 : 32'd2);
        g++;
      end
      if (rsp_valid) begin
        chk("contention_rsp_id", 32'(rsp_id), 32'(r % 2));
        r++;
      end
    end
    chk("contention_grants", 32'(g), 32'd4);
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();

    // Known-answer operations.
    do_op("sll",    0, 8'h81, 3'd3, 2'b00, 8'h08);
    do_op("sra",    1, 8'h90, 3'd2, 2'b10, 8'hE4);
    do_op("srl",    0, 8'h90, 3'd4, 2'b01, 8'h09);
    do_op("rol1",   1, 8'h81, 3'd1, 2'b11, 8'h03);
    do_op("rol0",   0, 8'h81, 3'd0, 2'b11, 8'h81);
    do_op("srl_ff", 1, 8'hFF, 3'd7, 2'b01, 8'h01);

    // Backpressure: result held while rsp_ready is low, and no new grant
    // until the cycle after the handshake.
    rsp_ready = 1'b0;
    set_req(0, 8'h01, 3'd7, 2'b00);
    req_valid[0] = 1'b1;
    wait_grant(0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    set_req(1, 8'hF0, 3'd1, 2'b01);
    req_valid[1] = 1'b1;
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        k = c;
        break;
      end
    end
    chk("bp_latency", 32'(k), 32'd8);
    for (int c = 0; c < 5; c++) begin
      chk("bp_data", 32'(rsp_data), 32'h80);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
      if (c < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", 32'(rsp_valid), 32'd1);
    chk("bp_hs_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'd2);
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();

    // Reset in the middle of a shamt-6 operation from requester 0.
    set_req(0, 8'hA5, 3'd6, 2'b00);
    req_valid[0] = 1'b1;
    wait_grant(0);
    @(posedge clk);
    #1;
    set_req(0, 8'h5A, 3'd2, 2'b10);
    set_req(1, 8'h3C, 3'd2, 2'b11);
    req_valid = 2'b11;
    @(posedge clk);
    #2;
    arst = 1'b1;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_rsp_data", 32'(rsp_data), 32'd0);
    chk("arst_rsp_id", 32'(rsp_id), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    arst = 1'b0;
    @(negedge clk);
    chk("post_reset_grant", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();

    // Randomized traffic with random backpressure.
    acc_cnt = 0;
    for (int c = 0; c < 1500 && acc_cnt < 60; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (acc != '0) acc_cnt++;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          req_valid[i] = 1'b0;
          set_req(i, W'($urandom), SW'($urandom), 2'($urandom));
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, W'($urandom), SW'($urandom), 2'($urandom));
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    chk("random_accepts", 32'(acc_cnt >= 60), 32'd1);
    req_valid = '0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "time limit");
  end

endmodule
